// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the scanned seven-segment display: character codes,
// segment bit positions and the digit-buffer entry layout.
package seg_scan_display_pkg;

  localparam logic [4:0] CH_A     = 5'd10;
  localparam logic [4:0] CH_B     = 5'd11;
  localparam logic [4:0] CH_C     = 5'd12;
  localparam logic [4:0] CH_D     = 5'd13;
  localparam logic [4:0] CH_E     = 5'd14;
  localparam logic [4:0] CH_F     = 5'd15;
  localparam logic [4:0] CH_L     = 5'd16;
  localparam logic [4:0] CH_O     = 5'd17;
  localparam logic [4:0] CH_P     = 5'd18;
  localparam logic [4:0] CH_R     = 5'd19;
  localparam logic [4:0] CH_T     = 5'd20;
  localparam logic [4:0] CH_U     = 5'd21;
  localparam logic [4:0] CH_Y     = 5'd22;
  localparam logic [4:0] CH_N     = 5'd23;
  localparam logic [4:0] CH_DASH  = 5'd24;
  localparam logic [4:0] CH_BLANK = 5'd31;

  // Segment bit order on the tube buses: a..g in bits 0..6, dp in bit 7.
  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef struct packed {
    logic [4:0] ch;
    logic       dp;
    logic       blink;
  } cell_t;

  localparam cell_t CELL_BLANK = '{ch: CH_BLANK, dp: 1'b0, blink: 1'b0};

  function automatic logic [7:0] seg_pack(input logic [6:0] gfedcba, input logic dp);
    logic [7:0] s;
    s               = '0;
    s[SEG_G:SEG_A]  = gfedcba;
    s[SEG_DP]       = dp;
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_display_char_decode.sv
// Combinational character-code to active-high segment decoder.
module seg_char_decode
  import seg_scan_display_pkg::*;
(
  input  logic [4:0] char_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [6:0] gfedcba;

  always_comb begin
    gfedcba = 7'h00;
    case (char_i)
      5'd0:    gfedcba = 7'h3F;
      5'd1:    gfedcba = 7'h06;
      5'd2:    gfedcba = 7'h5B;
      5'd3:    gfedcba = 7'h4F;
      5'd4:    gfedcba = 7'h66;
      5'd5:    gfedcba = 7'h6D;
      5'd6:    gfedcba = 7'h7D;
      5'd7:    gfedcba = 7'h07;
      5'd8:    gfedcba = 7'h7F;
      5'd9:    gfedcba = 7'h6F;
      CH_A:    gfedcba = 7'h77;
      CH_B:    gfedcba = 7'h7C;
      CH_C:    gfedcba = 7'h39;
      CH_D:    gfedcba = 7'h5E;
      CH_E:    gfedcba = 7'h79;
      CH_F:    gfedcba = 7'h71;
      CH_L:    gfedcba = 7'h38;
      CH_O:    gfedcba = 7'h5C;
      CH_P:    gfedcba = 7'h73;
      CH_R:    gfedcba = 7'h50;
      CH_T:    gfedcba = 7'h78;
      CH_U:    gfedcba = 7'h1C;
      CH_Y:    gfedcba = 7'h6E;
      CH_N:    gfedcba = 7'h54;
      CH_DASH: gfedcba = 7'h40;
      default: gfedcba = 7'h00;
    endcase
    seg_o = seg_pack(gfedcba, dp_i);
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: per-digit character buffer, slot divider,
// free-running blink phase and registered digit/segment drive for two tube groups.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int SCAN_HZ  = 500,
  parameter int DIGITS   = 8,
  parameter int GROUP    = 4,
  parameter int BLINK_HZ = 2
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [4:0]        wr_char,
  input  logic              wr_dp,
  input  logic              wr_blink,
  input  logic              clear,
  output logic [DIGITS-1:0] seg_en,
  output logic              ctr1,
  output logic              ctr2,
  output logic [7:0]        tube1,
  output logic [7:0]        tube2
);

  localparam int SLOT       = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int DIV_W      = $clog2(SLOT + 1);
  localparam int BLK_W      = $clog2(BLINK_HALF + 1);
  localparam int IDX_W      = $clog2(DIGITS);
  localparam logic [IDX_W:0]    GROUP_L = (IDX_W + 1)'(GROUP);
  localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              phase_q, phase_d;
  logic              tick, blk_wrap;
  cell_t             buf_q [DIGITS];
  cell_t             buf_d [DIGITS];

  cell_t             cur;
  logic [7:0]        seg_raw, seg_vis;
  logic              in_g1;
  logic [DIGITS-1:0] seg_en_q, seg_en_d;
  logic              ctr1_q, ctr1_d, ctr2_q, ctr2_d;
  logic [7:0]        tube1_q, tube1_d, tube2_q, tube2_d;

  always_comb begin
    tick     = (div_q == DIV_W'(SLOT - 1));
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    if (tick) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    blk_wrap = (blk_q == BLK_W'(BLINK_HALF - 1));
    blk_d    = blk_wrap ? '0 : blk_q + 1'b1;
    phase_d  = phase_q ^ blk_wrap;
  end

  // Clear wins over a simultaneous write; out-of-range addresses match no entry.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      buf_d[i] = buf_q[i];
      if (clear)
        buf_d[i] = CELL_BLANK;
      else if (wr_en && (wr_addr == 4'(i)))
        buf_d[i] = '{ch: wr_char, dp: wr_dp, blink: wr_blink};
    end
  end

  assign cur = buf_q[idx_q];

  seg_char_decode u_decode (
    .char_i (cur.ch),
    .dp_i   (cur.dp),
    .seg_o  (seg_raw)
  );

  always_comb begin
    seg_vis  = (cur.blink && phase_q) ? 8'h00 : seg_raw;
    in_g1    = ({1'b0, idx_q} < GROUP_L);
    seg_en_d = ONE_HOT0 << idx_q;
    ctr1_d   = in_g1;
    ctr2_d   = !in_g1;
    tube1_d  = in_g1 ? seg_vis : 8'h00;
    tube2_d  = in_g1 ? 8'h00 : seg_vis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      idx_q    <= '0;
      blk_q    <= '0;
      phase_q  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) buf_q[i] <= CELL_BLANK;
      seg_en_q <= '0;
      ctr1_q   <= 1'b0;
      ctr2_q   <= 1'b0;
      tube1_q  <= 8'h00;
      tube2_q  <= 8'h00;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      blk_q    <= blk_d;
      phase_q  <= phase_d;
      for (int i = 0; i < DIGITS; i++) buf_q[i] <= buf_d[i];
      seg_en_q <= seg_en_d;
      ctr1_q   <= ctr1_d;
      ctr2_q   <= ctr2_d;
      tube1_q  <= tube1_d;
      tube2_q  <= tube2_d;
    end
  end

  assign seg_en = seg_en_q;
  assign ctr1   = ctr1_q;
  assign ctr2   = ctr2_q;
  assign tube1  = tube1_q;
  assign tube2  = tube2_q;

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter CLK_HZ, 100000000, system clock frequency.
REQ-002 Parameter SCAN_HZ, 500, full-frame refresh rate; per-digit slot = CLK_HZ/(SCAN_HZ*DIGITS) clocks, integer and >=2.
REQ-003 Parameter DIGITS, 8, number of scanned digits; range 2..16.
REQ-004 Parameter GROUP, 4, digits driven from tube1; digits GROUP..DIGITS-1 are driven from tube2.
REQ-005 Parameter BLINK_HZ, 2, blink toggle frequency; phase flips every CLK_HZ/(2*BLINK_HZ) clocks.
REQ-006 clk  in  1  system clock, rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 wr_en  in  1  write strobe for the digit buffer.
REQ-009 wr_addr  in  4  digit index to write.
REQ-010 wr_char  in  5  character code to store.
REQ-011 wr_dp  in  1  decimal-point bit to store.
REQ-012 wr_blink  in  1  blink-enable bit to store.
REQ-013 clear  in  1  blank the whole buffer.
REQ-014 seg_en  out  DIGITS  one-hot digit enable, active-high.
REQ-015 ctr1 / ctr2  out  1  group enables: ctr1=1 while a digit <GROUP is scanned, ctr2=1 otherwise.
REQ-016 tube1 / tube2  out  8  segments, active-high; bit0=a..bit6=g, bit7=dp.

Function
REQ-017 A divider SHALL count 0..SLOT-1 and emit a 1-clock tick at terminal count, then wrap to 0.
REQ-018 On tick, scan_idx SHALL advance by 1 and wrap from DIGITS-1 to 0.
REQ-019 The buffer SHALL hold {char[4:0], dp, blink} per digit in registers.
REQ-020 A write is sampled at a rising edge with wr_en=1 and wr_addr<DIGITS; writes with wr_addr>=DIGITS SHALL be ignored.
REQ-021 clear=1 SHALL set every entry to char=31, dp=0, blink=0; clear SHALL take priority over a simultaneous write.
REQ-022 All outputs SHALL be registered and derived from the current scan_idx, buffer and blink phase; a write sampled at edge k SHALL appear on the outputs at edge k+1 when its digit is being scanned.
REQ-023 seg_en SHALL equal 1<<scan_idx, with ctr1/ctr2 per REQ-015.
REQ-024 The active group's tube SHALL carry the decoded segments; the inactive tube SHALL be 8'h00.
REQ-025 Decode: codes 0-9 -> digits; 10-15 -> A b C d E F; 16 L, 17 o, 18 P, 19 r, 20 t, 21 u, 22 y, 23 n, 24 '-'; codes 25-31 -> blank.
REQ-026 When a digit's blink bit=1 and blink phase=1, its segments and dp SHALL be 0; seg_en still scans.
REQ-027 The blink counter SHALL run freely, independent of writes and scan.

Reset
REQ-028 While rst_n=0: divider, scan_idx and blink phase SHALL be 0; buffer entries char=31, dp=0, blink=0; seg_en, tube1, tube2, ctr1 and ctr2 SHALL be 0.
REQ-029 At the first rising edge after release, seg_en SHALL become 1 and ctr1 SHALL become 1; reset asserted mid-frame SHALL abort the scan immediately.

Structure
REQ-030 Character code constants, the blank code (31) and the segment bit order SHALL be defined in the shared constants header.
REQ-031 Decoding SHALL be implemented in a sub-module seg_char_decode (char, dp -> 8-bit segments), purely combinational.

Verification (CLK_HZ=80, SCAN_HZ=1, DIGITS=8, GROUP=4, BLINK_HZ=2, giving a 10-clock slot)
REQ-032 Reset release, no writes -> seg_en steps 01,02,..80,01 every 10 clocks; tube1/tube2 stay 00; ctr1=1 for the first 40 clocks and ctr2=1 for the next 40.
REQ-033 Write addr0=1, addr1=2, addr4=24 with dp -> tube1=06 in slot 0 and 5B in slot 1; tube2=C0 in slot 4; the inactive tube is 00.
REQ-034 Write addr2=10 with blink=1 -> slot 2 shows 77 during phase 0 and 00 during phase 1 (20-clock toggle); other digits are unaffected.
REQ-035 Same-cycle clear and write addr3=5 -> all digits blank; a write to addr 9 -> no change.
REQ-036 Write to the currently scanned digit mid-slot -> new segments appear on the next clock; rst_n pulsed mid-frame -> all outputs 0, buffer blank, scan restarts at digit 0.
